vector_activation: RTL and testbench

VECTOR_ACTIVATION -- requirements
Module: vector_activation

---
 rtl/vector_activation_pkg.sv | 20 ++
 rtl/activation_alu.sv | 22 ++
 rtl/vector_activation.sv | 140 ++++++++++++++
 tb/tb_vector_activation.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_activation_pkg.sv
// Shared constants for the vector activation engine.
// Bus encodings, FSM state codes and default element width.
package vector_activation_pkg;

  localparam int TYPE_BW_DEF = 32;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b11;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_RD_LEN  = 3'd1;
  localparam state_t ST_RD_ELEM = 3'd2;
  localparam state_t ST_WR_ELEM = 3'd3;
  localparam state_t ST_GAP     = 3'd4;
  localparam state_t ST_FIN     = 3'd5;

endpackage

// File: rtl/activation_alu.sv
// Combinational activation: ReLU, or leaky x>>>3 for
// negative inputs when ACT_LEAKY_EN is defined.
module activation_alu #(
  parameter int TYPE_BW = 32
) (
  input  logic [TYPE_BW-1:0] x,
  output logic [TYPE_BW-1:0] y
);

  // Negative inputs are clamped to zero or scaled down by 8
  always_comb begin
    y = x;
    if (x[TYPE_BW-1]) begin
`ifdef ACT_LEAKY_EN
      y = $signed(x) >>> 3;
`else
      y = '0;
`endif
    end
  end

endmodule

// File: rtl/vector_activation.sv
// Reads N elements from SRAM, applies the activation, writes back.
// ACT_LEAKY_EN selects the leaky variant inside activation_alu.
module vector_activation
  import vector_activation_pkg::*;
#(
  parameter int          TYPE_BW  = TYPE_BW_DEF,
  parameter logic [31:0] LEN_ADDR = 32'h0,
  parameter logic [31:0] SRC_BASE = 32'h1,
  parameter logic [31:0] DST_BASE = 32'h40,
  parameter int          MAX_LEN  = 128
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  output logic               done,
  output logic [31:0]        addr_o,
  input  logic [TYPE_BW-1:0] data_i,
  output logic [TYPE_BW-1:0] data_o,
  output logic [1:0]         mem_operation,
  input  logic               mem_opdone
);

  localparam int LW = (TYPE_BW > 32) ? TYPE_BW : 32;

  state_t       state;
  state_t       gap_tgt;
  logic [31:0]  n;
  logic [31:0]  i;
  logic         abort;
  logic         pending;
  logic         leave;
  logic [LW-1:0] len_ext;
  logic [31:0]  len_clamped;
  logic [31:0]  i_next;
  logic [TYPE_BW-1:0] act_y;

  activation_alu #(
    .TYPE_BW(TYPE_BW)
  ) u_alu (
    .x(data_i),
    .y(act_y)
  );

  // Exit conditions and the clamped element count
  always_comb begin
    pending = (state == ST_RD_LEN) ||
              (state == ST_RD_ELEM) ||
              (state == ST_WR_ELEM);
    leave = pending ? (mem_opdone && (abort || !enable))
                    : !enable;
    len_ext = LW'(data_i);
    len_clamped = (len_ext > LW'(MAX_LEN)) ? 32'(MAX_LEN)
                                           : 32'(len_ext);
    i_next = i + 32'd1;
  end

  // Job sequencer; bus outputs are registered and held per access
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= ST_IDLE;
      gap_tgt       <= ST_IDLE;
      done          <= 1'b0;
      mem_operation <= MEM_NONE;
      addr_o        <= '0;
      data_o        <= '0;
      n             <= '0;
      i             <= '0;
      abort         <= 1'b0;
    end else if (leave) begin
      state         <= ST_IDLE;
      gap_tgt       <= ST_IDLE;
      done          <= 1'b0;
      mem_operation <= MEM_NONE;
      addr_o        <= '0;
      data_o        <= '0;
      n             <= '0;
      i             <= '0;
      abort         <= 1'b0;
    end else begin
      if (pending && !enable)
        abort <= 1'b1;
      case (state)
        ST_IDLE: begin
          state         <= ST_RD_LEN;
          mem_operation <= MEM_READ;
          addr_o        <= LEN_ADDR;
        end
        ST_RD_LEN: begin
          if (mem_opdone) begin
            n             <= len_clamped;
            i             <= '0;
            mem_operation <= MEM_NONE;
            state         <= ST_GAP;
            gap_tgt       <= (len_clamped == 32'd0) ? ST_FIN
                                                    : ST_RD_ELEM;
          end
        end
        ST_RD_ELEM: begin
          if (mem_opdone) begin
            data_o        <= act_y;
            mem_operation <= MEM_NONE;
            state         <= ST_GAP;
            gap_tgt       <= ST_WR_ELEM;
          end
        end
        ST_WR_ELEM: begin
          if (mem_opdone) begin
            i             <= i_next;
            mem_operation <= MEM_NONE;
            state         <= ST_GAP;
            gap_tgt       <= (i_next < n) ? ST_RD_ELEM : ST_FIN;
          end
        end
        ST_GAP: begin
          state <= gap_tgt;
          case (gap_tgt)
            ST_RD_ELEM: begin
              mem_operation <= MEM_READ;
              addr_o        <= SRC_BASE + i;
            end
            ST_WR_ELEM: begin
              mem_operation <= MEM_WRITE;
              addr_o        <= DST_BASE + i;
            end
            default: begin
              done <= 1'b1;
            end
          endcase
        end
        ST_FIN: begin
          done <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vector_activation.sv
// Randomized directed bench for vector_activation with a memory
// responder and an arithmetic reference model of the activation.
module tb_vector_activation;
  import vector_activation_pkg::*;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        done;
  logic [31:0] addr_o;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic [1:0]  mem_operation;
  logic        mem_opdone;

  logic [31:0] mem [0:255];
  int checks = 0;
  int failures = 0;
  int lat = 0;
  int n_wr = 0;
  int n_req = 0;

  vector_activation #(
    .TYPE_BW(32),
    .LEN_ADDR(32'h0),
    .SRC_BASE(32'h1),
    .DST_BASE(32'h40),
    .MAX_LEN(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .done(done),
    .addr_o(addr_o),
    .data_i(data_i),
    .data_o(data_o),
    .mem_operation(mem_operation),
    .mem_opdone(mem_opdone)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] act(input logic [31:0] x);
    longint v;
    v = longint'($signed(x));
    if (v < 0) begin
`ifdef ACT_LEAKY_EN
      return 32'((v - 7) / 8);
`else
      return 32'h0;
`endif
    end
    return x;
  endfunction

  // Memory responder: fixed latency, stability and gap checks
  initial begin : responder
    bit          pend;
    int          wcnt;
    int          zeros;
    logic [1:0]  l_op;
    logic [31:0] l_addr;
    logic [31:0] l_data;
    pend = 0;
    wcnt = 0;
    zeros = 100;
    mem_opdone = 1'b0;
    data_i = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_opdone = 1'b0;
      if (mem_operation == MEM_NONE) begin
        pend = 0;
        zeros++;
      end else begin
        if (!pend) begin
          pend = 1;
          wcnt = 0;
          l_op = mem_operation;
          l_addr = addr_o;
          l_data = data_o;
          n_req++;
          if (!(mem_operation == MEM_READ && addr_o == 32'h0))
            check("gap_len", 64'(zeros), 64'd1);
        end else begin
          check("stable_op", 64'(mem_operation), 64'(l_op));
          check("stable_addr", 64'(addr_o), 64'(l_addr));
          check("stable_data", 64'(data_o), 64'(l_data));
        end
        if (wcnt >= lat) begin
          mem_opdone = 1'b1;
          pend = 0;
          zeros = 0;
          if (mem_operation == MEM_READ) begin
            data_i = mem[addr_o[7:0]];
          end else begin
            mem[addr_o[7:0]] = data_o;
            n_wr++;
          end
        end else begin
          wcnt++;
        end
      end
    end
  end

  task automatic fill_src(input bit rnd);
    for (int k = 1; k <= 20; k++)
      if (rnd) mem[k] = $urandom;
    for (int k = 0; k < 24; k++)
      mem[8'h40 + k] = 32'hDEAD_BEEF;
  endtask

  task automatic run_job(input logic [31:0] len, input int lat_v);
    int n_eff;
    int t;
    logic [31:0] src [0:19];
    lat = lat_v;
    mem[0] = len;
    for (int k = 0; k < 20; k++) src[k] = mem[k + 1];
    n_eff = (len > 32'd16) ? 16 : int'(len);
    n_wr = 0;
    @(posedge clk);
    #2 enable = 1'b1;
    t = 0;
    while (done !== 1'b1 && t < 5000) begin
      @(posedge clk);
      #2;
      t++;
    end
    check("job_done", 64'(done), 64'd1);
    check("wr_count", 64'(n_wr), 64'(n_eff));
    for (int k = 0; k < n_eff; k++)
      check("dst_val", 64'(mem[8'h40 + k]), 64'(act(src[k])));
    check("dst_tail", 64'(mem[8'h40 + n_eff]), 64'hDEAD_BEEF);
    @(posedge clk);
    #2;
    check("done_hold", 64'(done), 64'd1);
    check("fin_op", 64'(mem_operation), 64'(MEM_NONE));
    enable = 1'b0;
    @(posedge clk);
    #2;
    check("done_clr", 64'(done), 64'd0);
    check("idle_state", 64'(dut.state), 64'(ST_IDLE));
  endtask

  initial begin : main
    int t;
    int r0;
    reset = 1'b0;
    enable = 1'b0;
    for (int k = 0; k < 256; k++) mem[k] = '0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_done", 64'(done), 64'd0);
    check("rst_op", 64'(mem_operation), 64'(MEM_NONE));
    check("rst_addr", 64'(addr_o), 64'd0);
    check("rst_data", 64'(data_o), 64'd0);
    check("rst_state", 64'(dut.state), 64'(ST_IDLE));
    reset = 1'b1;

    @(posedge clk);
    #2 mem_opdone = 1'b1;
    @(posedge clk);
    #2;
    check("spur_op", 64'(mem_operation), 64'(MEM_NONE));
    check("spur_state", 64'(dut.state), 64'(ST_IDLE));

    fill_src(0);
    mem[1] = 32'd5;
    mem[2] = -32'sd3;
    mem[3] = 32'd0;
    mem[4] = -32'sd16;
    run_job(32'd4, 0);

    fill_src(1);
    run_job(32'd0, 1);

    fill_src(1);
    run_job(32'hFFFF_FFFF, 0);

    fill_src(1);
    run_job(32'd3, 5);

    for (int j = 0; j < 4; j++) begin
      fill_src(1);
      run_job(32'($urandom_range(20, 1)), int'($urandom_range(3, 0)));
    end

    fill_src(1);
    lat = 3;
    mem[0] = 32'd4;
    n_wr = 0;
    enable = 1'b1;
    t = 0;
    while (!(mem_operation == MEM_READ && addr_o == 32'h2) &&
           t < 500) begin
      @(posedge clk);
      #2;
      t++;
    end
    check("abort_reach", 64'(t < 500), 64'd1);
    enable = 1'b0;
    r0 = n_req;
    t = 0;
    while (mem_opdone !== 1'b1 && t < 50) begin
      @(posedge clk);
      #2;
      t++;
    end
    check("abort_opdone", 64'(mem_opdone), 64'd1);
    @(posedge clk);
    #2;
    check("abort_state", 64'(dut.state), 64'(ST_IDLE));
    check("abort_done", 64'(done), 64'd0);
    repeat (6) @(posedge clk);
    #2;
    check("abort_noreq", 64'(n_req), 64'(r0));
    check("abort_op", 64'(mem_operation), 64'(MEM_NONE));
    check("abort_wr", 64'(n_wr), 64'd1);

    fill_src(1);
    lat = 2;
    mem[0] = 32'd6;
    enable = 1'b1;
    t = 0;
    while (mem_operation != MEM_WRITE && t < 500) begin
      @(posedge clk);
      #2;
      t++;
    end
    check("rst_reach", 64'(t < 500), 64'd1);
    reset = 1'b0;
    @(posedge clk);
    #2;
    check("mrst_op", 64'(mem_operation), 64'(MEM_NONE));
    check("mrst_addr", 64'(addr_o), 64'd0);
    check("mrst_data", 64'(data_o), 64'd0);
    check("mrst_done", 64'(done), 64'd0);
    check("mrst_state", 64'(dut.state), 64'(ST_IDLE));
    reset = 1'b1;
    enable = 1'b0;
    fill_src(1);
    run_job(32'd5, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
